// File: rtl/traffic_light_ctrl.sv
// Two-approach intersection controller with pedestrian walk phase and emergency all-red hold.
// Ports: clk, reset (sync, active-high); ped_req (pulse), emerg (level);
//        light_ns/light_ew (00=R 01=Y 10=G), walk, phase (state code), ped_pending (latched request).
module traffic_light_ctrl #(
   parameter int GREEN_CYCLES   = 8,
   parameter int YELLOW_CYCLES  = 3,
   parameter int ALL_RED_CYCLES = 2,
   parameter int WALK_CYCLES    = 5,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req,
   input  logic       emerg,
   output logic [1:0] light_ns,
   output logic [1:0] light_ew,
   output logic       walk,
   output logic [2:0] phase,
   output logic       ped_pending
);

   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      AR_A = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      AR_B = 3'd5,
      WALK = 3'd6,
      EMRG = 3'd7
   } state_t;

   localparam logic [1:0] LAMP_R = 2'b00;
   localparam logic [1:0] LAMP_Y = 2'b01;
   localparam logic [1:0] LAMP_G = 2'b10;

   // Counter load values are duration-1 so that a state lasts exactly its duration.
   localparam logic [CNT_W-1:0] G_LOAD  = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] Y_LOAD  = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'(ALL_RED_CYCLES - 1);
   localparam logic [CNT_W-1:0] W_LOAD  = CNT_W'(WALK_CYCLES - 1);

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;
   logic             walk_to_ew;   // WALK returns to EW_G when it was entered from AR_A
   logic             ped_any;

   assign cnt_zero = (cnt == '0);
   assign ped_any  = ped_pending | ped_req;

   function automatic logic [CNT_W-1:0] load_for(input state_t s);
      logic [CNT_W-1:0] v;
      v = '0;
      case (s)
         NS_G, EW_G: v = G_LOAD;
         NS_Y, EW_Y: v = Y_LOAD;
         AR_A, AR_B: v = AR_LOAD;
         WALK:       v = W_LOAD;
         default:    v = '0;   // EMRG is untimed
      endcase
      return v;
   endfunction

   // Next-state logic. Emergency truncates green only; yellow and all-red always
   // complete, and emergency beats a pedestrian request at all-red expiry.
   always_comb begin
      nxt = state;
      case (state)
         NS_G: if (emerg || cnt_zero) nxt = NS_Y;
         NS_Y: if (cnt_zero) nxt = AR_A;
         AR_A: if (cnt_zero) begin
                  if (emerg)        nxt = EMRG;
                  else if (ped_any) nxt = WALK;
                  else              nxt = EW_G;
               end
         EW_G: if (emerg || cnt_zero) nxt = EW_Y;
         EW_Y: if (cnt_zero) nxt = AR_B;
         AR_B: if (cnt_zero) begin
                  if (emerg)        nxt = EMRG;
                  else if (ped_any) nxt = WALK;
                  else              nxt = NS_G;
               end
         WALK: begin
                  if (emerg)         nxt = EMRG;
                  else if (cnt_zero) nxt = walk_to_ew ? EW_G : NS_G;
               end
         EMRG: if (!emerg) nxt = AR_B;
         default: nxt = AR_B;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= AR_B;
         cnt         <= AR_LOAD;
         ped_pending <= 1'b0;
         walk_to_ew  <= 1'b0;
         light_ns    <= LAMP_R;
         light_ew    <= LAMP_R;
         walk        <= 1'b0;
         phase       <= AR_B;
      end else begin
         state <= nxt;
         phase <= nxt;

         if (nxt != state)
            cnt <= load_for(nxt);
         else if (!cnt_zero)
            cnt <= cnt - 1'b1;

         // Entering WALK serves the request, including one arriving that same cycle.
         if (nxt == WALK && state != WALK) begin
            ped_pending <= 1'b0;
            walk_to_ew  <= (state == AR_A);
         end else if (ped_req && state != WALK) begin
            ped_pending <= 1'b1;
         end

         // Lamps are decoded from the next state so they line up with phase.
         light_ns <= (nxt == NS_G) ? LAMP_G : (nxt == NS_Y) ? LAMP_Y : LAMP_R;
         light_ew <= (nxt == EW_G) ? LAMP_G : (nxt == EW_Y) ? LAMP_Y : LAMP_R;
         walk     <= (nxt == WALK);
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed-vector bench for traffic_light_ctrl with an expected-value scoreboard.
// Ports: drives clk, reset, ped_req, emerg; observes lamps, walk, phase, ped_pending.
module tb_traffic_light_ctrl;

   logic       clk;
   logic       reset;
   logic       ped_req;
   logic       emerg;
   logic [1:0] light_ns;
   logic [1:0] light_ew;
   logic       walk;
   logic [2:0] phase;
   logic       ped_pending;

   int tests_run = 0;
   int tests_failed = 0;

   // Expected {phase[2:0], ns[1:0], ew[1:0], walk, ped_pending}
   logic [8:0] exp_q[$];

   traffic_light_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .ped_req     (ped_req),
      .emerg       (emerg),
      .light_ns    (light_ns),
      .light_ew    (light_ew),
      .walk        (walk),
      .phase       (phase),
      .ped_pending (ped_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lamp table written from the state/lamp definition.
   function automatic logic [8:0] pack(input logic [2:0] ph, input logic pp);
      logic [1:0] ns;
      logic [1:0] ew;
      logic       wk;
      ns = 2'b00;
      ew = 2'b00;
      wk = 1'b0;
      case (ph)
         3'd0: ns = 2'b10;
         3'd1: ns = 2'b01;
         3'd3: ew = 2'b10;
         3'd4: ew = 2'b01;
         3'd6: wk = 1'b1;
         default: ;
      endcase
      return {ph, ns, ew, wk, pp};
   endfunction

   // One clock: apply inputs, and after the edge record what the DUT must show.
   task automatic step(input logic r, input logic p, input logic e,
                       input logic [2:0] ph, input logic pp);
      reset   = r;
      ped_req = p;
      emerg   = e;
      @(posedge clk);
      exp_q.push_back(pack(ph, pp));
      #1;
   endtask

   task automatic run(input int n, input logic [2:0] ph, input logic pp);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, ph, pp);
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle.
   always @(negedge clk) begin
      logic [8:0] e;
      logic [8:0] got;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {phase, light_ns, light_ew, walk, ped_pending};
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL outputs @%0t: got phase=%0d ns=%b ew=%b walk=%b pp=%b, want phase=%0d ns=%b ew=%b walk=%b pp=%b",
                     $time, got[8:6], got[5:4], got[3:2], got[1], got[0],
                     e[8:6], e[5:4], e[3:2], e[1], e[0]);
         end
         tests_run++;
         if ((light_ns != 2'b00 && light_ew != 2'b00) || light_ns === 2'b11 || light_ew === 2'b11) begin
            tests_failed++;
            $display("FAIL lamp_safety @%0t: ns=%b ew=%b, want at least one red and no 11",
                     $time, light_ns, light_ew);
         end
      end
   end

   initial begin
      reset   = 1'b1;
      ped_req = 1'b0;
      emerg   = 1'b0;

      // Reset, then a full idle period: AR_B 2, NS_G 8, NS_Y 3, AR_A 2, EW_G 8, EW_Y 3, AR_B 2.
      step(1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
      run(1, 3'd5, 1'b0);
      run(8, 3'd0, 1'b0);
      run(3, 3'd1, 1'b0);
      run(2, 3'd2, 1'b0);
      run(8, 3'd3, 1'b0);
      run(3, 3'd4, 1'b0);
      run(2, 3'd5, 1'b0);
      run(1, 3'd0, 1'b0);

      // Pedestrian pulse in EW_G: WALK after AR_B, then NS_G.
      run(7, 3'd0, 1'b0);
      run(3, 3'd1, 1'b0);
      run(2, 3'd2, 1'b0);
      run(1, 3'd3, 1'b0);
      step(1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
      run(6, 3'd3, 1'b1);
      run(3, 3'd4, 1'b1);
      run(2, 3'd5, 1'b1);
      run(5, 3'd6, 1'b0);
      run(1, 3'd0, 1'b0);

      // Emergency in 3rd NS_G cycle: truncated green, full yellow/all-red, EMRG hold, AR_B exit.
      run(2, 3'd0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
      step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
      step(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
      step(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
      step(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
      step(1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
      run(1, 3'd5, 1'b0);
      run(1, 3'd0, 1'b0);

      // Pedestrian and emergency both pending at AR_A expiry: EMRG wins, WALK after exit.
      step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
      run(6, 3'd0, 1'b1);
      run(3, 3'd1, 1'b1);
      run(1, 3'd2, 1'b1);
      step(1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
      step(1'b0, 1'b0, 1'b1, 3'd7, 1'b1);
      step(1'b0, 1'b0, 1'b1, 3'd7, 1'b1);
      step(1'b0, 1'b0, 1'b0, 3'd5, 1'b1);
      run(1, 3'd5, 1'b1);
      run(5, 3'd6, 1'b0);
      run(1, 3'd0, 1'b0);

      // Emergency pulse truncates green, drops during yellow: normal resume, no EMRG.
      step(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
      run(2, 3'd1, 1'b0);
      run(2, 3'd2, 1'b0);
      run(1, 3'd3, 1'b0);

      // Request coincident with WALK entry absorbed, request in WALK ignored, reset mid-WALK.
      step(1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
      run(6, 3'd3, 1'b1);
      run(3, 3'd4, 1'b1);
      run(1, 3'd5, 1'b1);
      step(1'b0, 1'b1, 1'b0, 3'd5, 1'b1);
      step(1'b0, 1'b1, 1'b0, 3'd6, 1'b0);
      step(1'b0, 1'b1, 1'b0, 3'd6, 1'b0);
      step(1'b1, 1'b1, 1'b1, 3'd5, 1'b0);
      run(1, 3'd5, 1'b0);
      run(2, 3'd0, 1'b0);

      @(negedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
